// File: rtl/sram_like_bridge.sv
// Bridge from the CPU's fixed-latency data SRAM port to a split-transaction SRAM-like bus.
// Optional request timeout enabled by defining SRAM_LIKE_BRIDGE_TIMEOUT_EN.
module sram_like_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_r, state_next;
    logic        req_r, wr_r;
    logic [1:0]  size_r;
    logic [3:0]  wstrb_r;
    logic [31:0] addr_r, wdata_r, rdata_r;
    logic        capture_s, tmo_fire_s, timeout_s;

    // Transfer size implied by the byte-enable pattern; reads and irregular masks use a word.
    function automatic logic [1:0] size_of(input logic [3:0] we);
        case (we)
            4'b1111:                            size_of = 2'd2;
            4'b0011, 4'b1100:                   size_of = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 2'd0;
            default:                            size_of = 2'd2;
        endcase
    endfunction

    // Next-state decode; a genuine completion takes priority over a timeout in the same cycle.
    always_comb begin
        state_next = state_r;
        capture_s  = 1'b0;
        tmo_fire_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_en) state_next = REQ;
                else        state_next = IDLE;
            end
            REQ: begin
                if (addr_ok && data_ok) begin
                    state_next = RESP;
                    capture_s  = 1'b1;
                end else if (timeout_s) begin
                    state_next = RESP;
                    tmo_fire_s = 1'b1;
                end else if (addr_ok) begin
                    state_next = WAIT;
                end else begin
                    state_next = REQ;
                end
            end
            WAIT: begin
                if (data_ok) begin
                    state_next = RESP;
                    capture_s  = 1'b1;
                end else if (timeout_s) begin
                    state_next = RESP;
                    tmo_fire_s = 1'b1;
                end else begin
                    state_next = WAIT;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall is combinational so the requesting IDLE cycle itself holds the pipeline.
    always_comb begin
        cpu_stall = 1'b0;
        if (reset)                 cpu_stall = 1'b0;
        else if (state_r == IDLE)  cpu_stall = cpu_en;
        else if (state_r == RESP)  cpu_stall = 1'b0;
        else                       cpu_stall = 1'b1;
    end

    // State, request latches and returned read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            wr_r    <= 1'b0;
            size_r  <= 2'd0;
            wstrb_r <= 4'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            rdata_r <= 32'd0;
        end else begin
            state_r <= state_next;
            req_r   <= (state_next == REQ);
            if ((state_r == IDLE) && cpu_en) begin
                wstrb_r <= cpu_we;
                wr_r    <= |cpu_we;
                size_r  <= size_of(cpu_we);
                addr_r  <= cpu_addr;
                wdata_r <= cpu_wdata;
            end
            if (capture_s && !wr_r)       rdata_r <= rdata;
            else if (tmo_fire_s && !wr_r) rdata_r <= ERR_RDATA;
        end
    end

`ifdef SRAM_LIKE_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             bus_err_r;

    // The counter equals the number of REQ/WAIT cycles already elapsed, so the last one fires.
    assign timeout_s = ((state_r == REQ) || (state_r == WAIT)) &&
                       (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter and one-cycle error pulse coinciding with RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= '0;
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= tmo_fire_s;
            if ((state_r == REQ) || (state_r == WAIT)) tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            else                                       tmo_cnt_r <= '0;
        end
    end

    assign bus_err = bus_err_r;
`else
    // No timeout in this build; the parameter stays referenced so both builds share one interface.
    assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
    assign bus_err   = 1'b0;
`endif

    assign req       = req_r;
    assign wr        = wr_r;
    assign size      = size_r;
    assign wstrb     = wstrb_r;
    assign addr      = addr_r;
    assign wdata     = wdata_r;
    assign cpu_rdata = rdata_r;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: directed plan items plus randomized accesses
// scored against a per-transaction model of stall length, request count and returned data.
module tb_sram_like_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        bus_err;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] ref_rdata;

    sram_like_bridge dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Size expected from the byte-enable mask.
    function automatic logic [1:0] exp_size(input logic [3:0] we);
        if (we == 4'b0011 || we == 4'b1100) return 2'd1;
        else if ($countones(we) == 1)       return 2'd0;
        else                                return 2'd2;
    endfunction

    // One CPU access. The bus accepts on the (ad)th req cycle (0-based) and returns data_ok
    // dd cycles after acceptance (0 = same cycle). Expected: stall = 1 + (ad+1) + dd cycles,
    // exactly ad+1 req cycles, then one non-stalled RESP cycle.
    task automatic do_access(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd,
                             input int ad, input int dd, input logic [31:0] rv, input bit noise);
        int  k, w, stalls, reqs;
        bit  acc, done;
        k = 0; w = 0; stalls = 0; reqs = 0; acc = 1'b0; done = 1'b0;
        @(negedge clk);
        cpu_en = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        addr_ok = 1'b0; data_ok = noise; rdata = $urandom;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            check("bus_err_idle", {31'd0, bus_err}, 32'd0);
            if (cyc > 0 && cpu_stall === 1'b0) begin
                if (we == 4'b0000) ref_rdata = rv;
                check("resp_rdata", cpu_rdata, ref_rdata);
                check("stall_cycles", stalls, 2 + ad + dd);
                check("req_cycles", reqs, ad + 1);
                check("resp_req_low", {31'd0, req}, 32'd0);
                cpu_en = 1'b0; addr_ok = 1'b0; data_ok = noise;
                done = 1'b1;
                break;
            end
            if (cpu_stall === 1'b1) stalls++;
            if (req === 1'b1) begin
                reqs++;
                check("req_addr", addr, a);
                check("req_wdata", wdata, wd);
                check("req_wstrb", {28'd0, wstrb}, {28'd0, we});
                check("req_wr", {31'd0, wr}, {31'd0, |we});
                check("req_size", {30'd0, size}, {30'd0, exp_size(we)});
            end
            if (acc) begin
                check("wait_addr_held", addr, a);
                check("wait_wdata_held", wdata, wd);
            end
            addr_ok = 1'b0; data_ok = 1'b0; rdata = $urandom;
            if (req === 1'b1 && !acc) begin
                if (k == ad) begin
                    addr_ok = 1'b1; acc = 1'b1;
                    if (dd == 0) begin data_ok = 1'b1; rdata = rv; end
                end else begin
                    data_ok = noise && ($urandom_range(1, 0) == 1);
                end
                k++;
            end else if (acc) begin
                w++;
                if (w == dd) begin data_ok = 1'b1; rdata = rv; end
                cpu_addr = $urandom; cpu_wdata = $urandom;
            end
            @(negedge clk);
        end
        if (!done) begin
            check("access_budget", 32'd0, 32'd1);
            cpu_en = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
        end
    endtask

    logic [3:0] pats [10] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b0101, 4'b0111};

    initial begin
        reset = 1'b1; cpu_en = 1'b1; cpu_we = 4'b1111;
        cpu_addr = 32'h1234_0000; cpu_wdata = 32'h5555_AAAA;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0; ref_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_wr", {31'd0, wr}, 32'd0);
        check("rst_size", {30'd0, size}, 32'd0);
        check("rst_wstrb", {28'd0, wstrb}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        cpu_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Word read completing in the request cycle.
        do_access(4'b0000, 32'h1C00_0010, 32'h0, 0, 0, 32'h1234_5678, 1'b0);
        // Byte write, addr_ok after 3 cycles, data_ok 2 cycles later.
        do_access(4'b1000, 32'h1C00_0003, 32'hAB00_0000, 3, 2, 32'hFFFF_0000, 1'b0);
        // Half write immediately followed by a word read.
        do_access(4'b1100, 32'h1C00_0102, 32'h7788_0000, 1, 1, 32'h0BAD_0BAD, 1'b0);
        do_access(4'b0000, 32'h1C00_0200, 32'h0000_0000, 0, 2, 32'hCAFE_F00D, 1'b0);

        // Reset while in WAIT.
        @(negedge clk);
        cpu_en = 1'b1; cpu_we = 4'b0000; cpu_addr = 32'h0000_1000; cpu_wdata = 32'd0;
        @(negedge clk);
        #1 check("rstw_req", {31'd0, req}, 32'd1);
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0;
        #1 check("rstw_wait_req", {31'd0, req}, 32'd0);
        check("rstw_wait_stall", {31'd0, cpu_stall}, 32'd1);
        reset = 1'b1; cpu_en = 1'b0;
        #1 check("rstw_stall_in_reset", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rstw_req_after", {31'd0, req}, 32'd0);
        check("rstw_stall_after", {31'd0, cpu_stall}, 32'd0);
        check("rstw_rdata_after", cpu_rdata, 32'd0);
        ref_rdata = 32'd0;
        do_access(4'b0000, 32'h0000_2000, 32'd0, 1, 1, 32'h3141_5926, 1'b0);

        // Randomized accesses with protocol-violating data_ok noise.
        for (int t = 0; t < 40; t++) begin
            do_access(pats[$urandom_range(9, 0)], $urandom, $urandom,
                      $urandom_range(3, 0), $urandom_range(3, 0), $urandom,
                      ($urandom_range(1, 0) == 1));
        end

        @(negedge clk);
        data_ok = 1'b0;
        #1 check("final_idle_stall", {31'd0, cpu_stall}, 32'd0);
        check("final_idle_req", {31'd0, req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
